// File: rtl/reg_move_sequencer.sv
// MOV8 register-to-register move sequencer: select source, load destination, release.
// All control outputs are registered from the next-state decode so sel/ld are glitch-free.
module reg_move_sequencer #(
    parameter int SEL_CYCLES  = 2,
    parameter int LD_CYCLES   = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [2:0] src,
    input  logic [2:0] dst,
    output logic       ack,
    output logic [7:0] sel,
    output logic [7:0] ld,
    output logic       busy,
    output logic       done,
    output logic [7:0] xfer_count
);

    // Phase lengths are expected to fit in 8 bits.
    typedef logic [7:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LOAD,
        HOLD,
        DONE
    } state_t;

    state_t     state, state_n;
    cnt_t       cnt, cnt_n;
    logic [2:0] src_l, src_n;
    logic [2:0] dst_l, dst_n;
    logic [7:0] count_n;
    logic       ack_n, busy_n, done_n;
    logic [7:0] sel_n, ld_n;
    logic       last;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        src_n   = src_l;
        dst_n   = dst_l;
        count_n = xfer_count;
        last    = (cnt == cnt_t'(1));

        case (state)
            IDLE: begin
                if (req) begin
                    state_n = SELECT;
                    cnt_n   = cnt_t'(SEL_CYCLES);
                    src_n   = src;
                    dst_n   = dst;
                end
            end
            SELECT: begin
                if (last) begin
                    state_n = LOAD;
                    cnt_n   = cnt_t'(LD_CYCLES);
                end else begin
                    cnt_n = cnt - cnt_t'(1);
                end
            end
            LOAD: begin
                if (last) begin
                    state_n = HOLD;
                    cnt_n   = cnt_t'(HOLD_CYCLES);
                end else begin
                    cnt_n = cnt - cnt_t'(1);
                end
            end
            HOLD: begin
                if (last) begin
                    state_n = DONE;
                    count_n = xfer_count + 8'd1;
                end else begin
                    cnt_n = cnt - cnt_t'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the upcoming state and registered alongside it.
        ack_n  = (state == IDLE) && (state_n == SELECT);
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
        sel_n  = '0;
        ld_n   = '0;
        if ((state_n == SELECT || state_n == LOAD || state_n == HOLD) && (src_n != dst_n))
            sel_n = 8'b1 << src_n;
        if (state_n == LOAD)
            ld_n = 8'b1 << dst_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            src_l      <= '0;
            dst_l      <= '0;
            xfer_count <= '0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sel        <= '0;
            ld         <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            src_l      <= src_n;
            dst_l      <= dst_n;
            xfer_count <= count_n;
            ack        <= ack_n;
            busy       <= busy_n;
            done       <= done_n;
            sel        <= sel_n;
            ld         <= ld_n;
        end
    end

endmodule

// File: tb/tb_reg_move_sequencer.sv
// Bench for reg_move_sequencer: default and (3,1,2) instances share stimulus and are
// compared each cycle against a move-offset reference model.
module tb_reg_move_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [2:0] src = '0;
    logic [2:0] dst = '0;

    logic       ack0, busy0, done0, ack1, busy1, done1;
    logic [7:0] sel0, ld0, cnt0, sel1, ld1, cnt1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    reg_move_sequencer dut0 (
        .clk(clk), .reset(reset), .req(req), .src(src), .dst(dst),
        .ack(ack0), .sel(sel0), .ld(ld0), .busy(busy0), .done(done0), .xfer_count(cnt0)
    );

    reg_move_sequencer #(.SEL_CYCLES(3), .LD_CYCLES(1), .HOLD_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .req(req), .src(src), .dst(dst),
        .ack(ack1), .sel(sel1), .ld(ld1), .busy(busy1), .done(done1), .xfer_count(cnt1)
    );

    // Reference model: a move is tracked by its cycle offset k since acceptance.
    int unsigned ps [2] = '{2, 3};
    int unsigned pl [2] = '{2, 1};
    int unsigned ph [2] = '{1, 2};
    bit          mact [2];
    int unsigned mk [2];
    logic [2:0]  ms [2];
    logic [2:0]  md [2];
    logic [7:0]  mcnt [2];
    bit          seen_wrap = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mact[i] = 1'b0;
            mk[i]   = 0;
            ms[i]   = '0;
            md[i]   = '0;
            mcnt[i] = '0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int unsigned total;
            total = ps[i] + pl[i] + ph[i];
            if (mact[i]) begin
                mk[i]++;
                if (mk[i] > total) mact[i] = 1'b0;
                else if (mk[i] == total) mcnt[i] = mcnt[i] + 8'd1;
            end else if (req) begin
                mact[i] = 1'b1;
                mk[i]   = 0;
                ms[i]   = src;
                md[i]   = dst;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int unsigned total;
            logic [7:0] e_sel, e_ld, o_sel, o_ld, o_cnt;
            logic e_ack, e_busy, e_done, o_ack, o_busy, o_done;
            total  = ps[i] + pl[i] + ph[i];
            e_busy = mact[i];
            e_ack  = mact[i] && (mk[i] == 0);
            e_done = mact[i] && (mk[i] == total);
            e_sel  = (mact[i] && mk[i] < total && ms[i] != md[i]) ? (8'd1 << ms[i]) : 8'd0;
            e_ld   = (mact[i] && mk[i] >= ps[i] && mk[i] < ps[i] + pl[i]) ? (8'd1 << md[i]) : 8'd0;
            o_sel  = (i == 0) ? sel0  : sel1;
            o_ld   = (i == 0) ? ld0   : ld1;
            o_cnt  = (i == 0) ? cnt0  : cnt1;
            o_ack  = (i == 0) ? ack0  : ack1;
            o_busy = (i == 0) ? busy0 : busy1;
            o_done = (i == 0) ? done0 : done1;
            chk($sformatf("sel%0d", i),   o_sel, e_sel);
            chk($sformatf("ld%0d", i),    o_ld, e_ld);
            chk($sformatf("ack%0d", i),   {7'd0, o_ack}, {7'd0, e_ack});
            chk($sformatf("busy%0d", i),  {7'd0, o_busy}, {7'd0, e_busy});
            chk($sformatf("done%0d", i),  {7'd0, o_done}, {7'd0, e_done});
            chk($sformatf("count%0d", i), o_cnt, mcnt[i]);
            chk($sformatf("onehot%0d", i), {7'd0, $onehot0(o_sel) && $onehot0(o_ld)}, 8'd1);
            chk($sformatf("ackdone%0d", i), {7'd0, o_ack && o_done}, 8'd0);
        end
    endtask

    logic [7:0] prev_cnt0 = '0;

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        if (prev_cnt0 == 8'hFF && cnt0 == 8'h00) seen_wrap = 1'b1;
        prev_cnt0 = cnt0;
    endtask

    task automatic idle_steps(input int unsigned n);
        req = 1'b0;
        for (int unsigned j = 0; j < n; j++) step();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of LOAD on a B->C move.
        req = 1'b1; src = 3'd1; dst = 3'd2;
        step();
        req = 1'b0;
        step();
        step();
        chk("midload_ld", ld0, 8'h04);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_sel0", sel0, 8'h00);
        chk("rst_ld0", ld0, 8'h00);
        chk("rst_busy0", {7'd0, busy0}, 8'd0);
        chk("rst_cnt0", cnt0, 8'h00);
        chk("rst_sel1", sel1, 8'h00);
        check_all();
        @(negedge clk);
        reset = 1'b0;
        idle_steps(3);
        chk("rst_nodone", {7'd0, done0 | done1}, 8'd0);

        // B->C with default timing, inputs scrambled after acceptance.
        req = 1'b1; src = 3'd1; dst = 3'd2;
        step();
        chk("bc_ack", {7'd0, ack0}, 8'd1);
        chk("bc_sel", sel0, 8'h02);
        req = 1'b0; src = 3'd6; dst = 3'd5;
        step();
        step();
        chk("bc_ld", ld0, 8'h04);
        step(); step(); step();
        chk("bc_done", {7'd0, done0}, 8'd1);
        chk("bc_count", cnt0, 8'd1);
        idle_steps(4);

        // Clear move D->D.
        req = 1'b1; src = 3'd3; dst = 3'd3;
        step();
        req = 1'b0;
        step(); step();
        chk("clr_sel", sel0, 8'h00);
        chk("clr_ld", ld0, 8'h08);
        idle_steps(6);

        // Request held while busy, with new operands presented mid-move.
        req = 1'b1; src = 3'd4; dst = 3'd6;
        step(); step();
        src = 3'd7; dst = 3'd0;
        for (int j = 0; j < 14; j++) step();
        idle_steps(6);

        // Continuous back-to-back moves to drive the count through its wrap.
        for (int j = 0; j < 1900; j++) begin
            req = 1'b1;
            src = 3'($urandom_range(0, 7));
            dst = 3'($urandom_range(0, 7));
            step();
        end
        chk("wrap_seen", {7'd0, seen_wrap}, 8'd1);

        // Random request pattern.
        for (int j = 0; j < 300; j++) begin
            req = ($urandom_range(0, 3) != 0);
            src = 3'($urandom_range(0, 7));
            dst = 3'($urandom_range(0, 7));
            step();
        end
        idle_steps(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
